// File: rtl/counter_pkg.sv
// Shared definitions for the counter primitives: direction and mode encodings
// plus a ceil-log2 helper used to size the prescaler register.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int unsigned MODE_WRAP = 0;
  localparam int unsigned MODE_SAT  = 1;

  // ceil(log2(n)); 0 for n <= 1
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    if (n > 1) begin
      for (int i = 0; i < 32; i++) begin
        if (((n - 1) >> i) != 0) r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable prescaler: counts enabled cycles 0..PRESCALE-1 and raises tick on
// the enabled cycle that completes a period.
//   clock         rising-edge clock
//   reset         synchronous, active-high reset
//   clear_or_load restart the period (count cleared or loaded)
//   enable        count enable; the period holds while low
//   tick          step strobe, combinational from enable and the period count
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_or_load,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CNT_W = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] r_cnt;

  // Period counter; returns to 0 after the ticking cycle
  always_ff @(posedge clock) begin
    if (reset || clear_or_load) begin
      r_cnt <= '0;
    end else if (enable) begin
      r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + CNT_W'(1);
    end
  end

  assign tick = enable && (r_cnt == LAST);

endmodule

// File: rtl/param_counter.sv
// General-purpose counter: programmable modulus, up/down, synchronous
// clear/load, wrap or saturate at the range ends, optional enable prescaler.
//   clock, reset  rising-edge clock, synchronous active-high reset
//   enable        count enable (gates prescaler and stepping)
//   up_down       1 = up, 0 = down, sampled per step
//   clear, load   synchronous clear / load of load_value (clamped to MAX_VALUE)
//   count         registered count
//   wrap          one-cycle pulse after a wrapping step
//   sat           level, count held at a range end by the last step
//   zero          registered count == 0
module param_counter
  import counter_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MAX_VALUE = 2**WIDTH - 1,
  parameter int unsigned SATURATE  = MODE_WRAP,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             sat,
  output logic             zero
);

  localparam logic [WIDTH-1:0] MAX_W = WIDTH'(MAX_VALUE);

  // Reject illegal parameterisations at elaboration
  if (WIDTH < 2) begin : g_bad_width
    $error("param_counter: WIDTH must be >= 2");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("param_counter: PRESCALE must be >= 1");
  end
  if (64'(MAX_VALUE) > ((64'(1) << WIDTH) - 64'(1))) begin : g_bad_max
    $error("param_counter: MAX_VALUE exceeds 2**WIDTH-1");
  end

  logic [WIDTH-1:0] r_count;
  logic             r_wrap;
  logic             r_sat;
  logic             r_zero;

  logic             w_tick;
  logic [WIDTH-1:0] w_step_count;
  logic             w_step_wrap;
  logic             w_step_sat;
  logic [WIDTH-1:0] w_load_clamped;

  // Step strobe: prescaled enable, or enable itself when PRESCALE is 1
  if (PRESCALE > 1) begin : g_prescale
    counter_prescaler #(
      .PRESCALE(PRESCALE)
    ) u_prescaler (
      .clock        (clock),
      .reset        (reset),
      .clear_or_load(clear | load),
      .enable       (enable),
      .tick         (w_tick)
    );
  end else begin : g_no_prescale
    assign w_tick = enable;
  end

  // Candidate result of a step and the clamped load value
  always_comb begin
    w_step_count = r_count;
    w_step_wrap  = 1'b0;
    w_step_sat   = 1'b0;
    if (up_down == DIR_UP) begin
      if (r_count != MAX_W) begin
        w_step_count = r_count + WIDTH'(1);
      end else if (SATURATE == MODE_SAT) begin
        w_step_sat = 1'b1;
      end else begin
        w_step_count = '0;
        w_step_wrap  = 1'b1;
      end
    end else begin
      if (r_count != '0) begin
        w_step_count = r_count - WIDTH'(1);
      end else if (SATURATE == MODE_SAT) begin
        w_step_sat = 1'b1;
      end else begin
        w_step_count = MAX_W;
        w_step_wrap  = 1'b1;
      end
    end
    w_load_clamped = (load_value > MAX_W) ? MAX_W : load_value;
  end

  // Priority: reset > clear > load > step > hold; sat holds between steps
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      r_count <= '0;
      r_wrap  <= 1'b0;
      r_sat   <= 1'b0;
      r_zero  <= 1'b1;
    end else if (load) begin
      r_count <= w_load_clamped;
      r_wrap  <= 1'b0;
      r_sat   <= 1'b0;
      r_zero  <= (w_load_clamped == '0);
    end else if (w_tick) begin
      r_count <= w_step_count;
      r_wrap  <= w_step_wrap;
      r_sat   <= w_step_sat;
      r_zero  <= (w_step_count == '0);
    end else begin
      r_wrap  <= 1'b0;
    end
  end

  assign count = r_count;
  assign wrap  = r_wrap;
  assign sat   = r_sat;
  assign zero  = r_zero;

endmodule

// File: tb/tb_param_counter.sv
// Scoreboard bench for param_counter: three instances (wrap, saturate,
// prescale-by-3), directed vectors with hand-computed expected outputs.
module tb_param_counter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       rst [3];
  logic       en  [3];
  logic       ud  [3];
  logic       clr [3];
  logic       ld  [3];
  logic [3:0] lv  [3];
  logic [3:0] cnt_o  [3];
  logic       wrap_o [3];
  logic       sat_o  [3];
  logic       zero_o [3];

  param_counter #(.WIDTH(4), .MAX_VALUE(9), .SATURATE(0), .PRESCALE(1)) dut_wrap (
    .clock(clock), .reset(rst[0]), .enable(en[0]), .up_down(ud[0]), .clear(clr[0]),
    .load(ld[0]), .load_value(lv[0]), .count(cnt_o[0]), .wrap(wrap_o[0]),
    .sat(sat_o[0]), .zero(zero_o[0]));

  param_counter #(.WIDTH(4), .MAX_VALUE(9), .SATURATE(1), .PRESCALE(1)) dut_sat (
    .clock(clock), .reset(rst[1]), .enable(en[1]), .up_down(ud[1]), .clear(clr[1]),
    .load(ld[1]), .load_value(lv[1]), .count(cnt_o[1]), .wrap(wrap_o[1]),
    .sat(sat_o[1]), .zero(zero_o[1]));

  param_counter #(.WIDTH(4), .MAX_VALUE(9), .SATURATE(0), .PRESCALE(3)) dut_pre (
    .clock(clock), .reset(rst[2]), .enable(en[2]), .up_down(ud[2]), .clear(clr[2]),
    .load(ld[2]), .load_value(lv[2]), .count(cnt_o[2]), .wrap(wrap_o[2]),
    .sat(sat_o[2]), .zero(zero_o[2]));

  typedef struct {
    int         dut;
    logic [3:0] cnt;
    logic       w;
    logic       s;
    logic       z;
    string      name;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  // Monitor: each pushed expectation is checked against its instance
  always @(negedge clock) begin
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      checks++;
      if (cnt_o[mon_e.dut] !== mon_e.cnt || wrap_o[mon_e.dut] !== mon_e.w ||
          sat_o[mon_e.dut] !== mon_e.s || zero_o[mon_e.dut] !== mon_e.z) begin
        errors++;
        $display("FAIL %s (dut %0d): got count=%0d wrap=%b sat=%b zero=%b, want count=%0d wrap=%b sat=%b zero=%b",
                 mon_e.name, mon_e.dut, cnt_o[mon_e.dut], wrap_o[mon_e.dut], sat_o[mon_e.dut],
                 zero_o[mon_e.dut], mon_e.cnt, mon_e.w, mon_e.s, mon_e.z);
      end
    end
  end

  // One clock of stimulus on instance d (others idle), then queue the expectation
  task automatic drive(input int d, input logic e, input logic u, input logic c,
                       input logic l, input logic [3:0] v, input logic r,
                       input logic [3:0] ec, input logic ew, input logic es,
                       input logic ez, input string nm);
    exp_t x;
    @(negedge clock);
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b0; en[i] = 1'b0; ud[i] = 1'b1; clr[i] = 1'b0; ld[i] = 1'b0; lv[i] = 4'd0;
    end
    rst[d] = r; en[d] = e; ud[d] = u; clr[d] = c; ld[d] = l; lv[d] = v;
    @(posedge clock);
    x.dut = d; x.cnt = ec; x.w = ew; x.s = es; x.z = ez; x.name = nm;
    sb.push_back(x);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 3; i++) begin
      rst[i] = 1'b1; en[i] = 1'b0; ud[i] = 1'b1; clr[i] = 1'b0; ld[i] = 1'b0; lv[i] = 4'd0;
    end
    repeat (2) @(posedge clock);

    // Wrap instance: reset, count up through MAX=9 with a wrap to 0
    drive(0, 0, 1, 0, 0, 0, 1, 4'd0, 0, 0, 1, "wrap_reset");
    for (int k = 1; k <= 9; k++) drive(0, 1, 1, 0, 0, 0, 0, 4'(k), 0, 0, 0, "wrap_up");
    drive(0, 1, 1, 0, 0, 0, 0, 4'd0, 1, 0, 1, "wrap_up_9_to_0");
    drive(0, 1, 1, 0, 0, 0, 0, 4'd1, 0, 0, 0, "wrap_pulse_clears");
    drive(0, 1, 1, 0, 0, 0, 0, 4'd2, 0, 0, 0, "wrap_up_2");
    drive(0, 0, 1, 0, 0, 0, 0, 4'd2, 0, 0, 0, "wrap_hold_disabled");
    // Load 2 then count down through 0 -> 9
    drive(0, 0, 0, 0, 1, 4'd2, 0, 4'd2, 0, 0, 0, "wrap_load_2");
    drive(0, 1, 0, 0, 0, 0, 0, 4'd1, 0, 0, 0, "wrap_down_1");
    drive(0, 1, 0, 0, 0, 0, 0, 4'd0, 0, 0, 1, "wrap_down_0");
    drive(0, 1, 0, 0, 0, 0, 0, 4'd9, 1, 0, 0, "wrap_down_0_to_9");
    drive(0, 1, 0, 0, 0, 0, 0, 4'd8, 0, 0, 0, "wrap_down_8");
    drive(0, 1, 0, 1, 1, 4'd5, 0, 4'd0, 0, 0, 1, "wrap_clear_beats_load");

    // Saturate instance: clamp on load, hold at ends, sat clears on a moving step
    drive(1, 0, 1, 0, 0, 0, 1, 4'd0, 0, 0, 1, "sat_reset");
    drive(1, 0, 1, 0, 1, 4'd15, 0, 4'd9, 0, 0, 0, "sat_load_clamp");
    drive(1, 1, 1, 0, 0, 0, 0, 4'd9, 0, 1, 0, "sat_up_hold_1");
    drive(1, 1, 1, 0, 0, 0, 0, 4'd9, 0, 1, 0, "sat_up_hold_2");
    drive(1, 0, 1, 0, 0, 0, 0, 4'd9, 0, 1, 0, "sat_level_holds");
    drive(1, 1, 0, 0, 0, 0, 0, 4'd8, 0, 0, 0, "sat_down_releases");
    drive(1, 0, 0, 0, 1, 4'd0, 0, 4'd0, 0, 0, 1, "sat_load_0");
    drive(1, 1, 0, 0, 0, 0, 0, 4'd0, 0, 1, 1, "sat_down_hold_0");
    drive(1, 0, 1, 0, 1, 4'd4, 0, 4'd4, 0, 0, 0, "sat_load_clears_sat");

    // Prescale-by-3 instance: steps on every third enabled cycle
    drive(2, 0, 1, 0, 0, 0, 1, 4'd0, 0, 0, 1, "pre_reset");
    for (int k = 1; k <= 9; k++)
      drive(2, 1, 1, 0, 0, 0, 0, 4'(k / 3), 0, 0, (k < 3), "pre_up");
    drive(2, 1, 1, 0, 0, 0, 0, 4'd3, 0, 0, 0, "pre_partial_1");
    drive(2, 1, 1, 0, 0, 0, 0, 4'd3, 0, 0, 0, "pre_partial_2");
    drive(2, 0, 1, 0, 0, 0, 0, 4'd3, 0, 0, 0, "pre_gap_1");
    drive(2, 0, 1, 0, 0, 0, 0, 4'd3, 0, 0, 0, "pre_gap_2");
    drive(2, 1, 1, 0, 0, 0, 0, 4'd4, 0, 0, 0, "pre_delayed_step");
    // Direction change mid-prescale takes effect on the next step
    drive(2, 1, 1, 0, 0, 0, 0, 4'd4, 0, 0, 0, "pre_dir_a");
    drive(2, 1, 0, 0, 0, 0, 0, 4'd4, 0, 0, 0, "pre_dir_b");
    drive(2, 1, 0, 0, 0, 0, 0, 4'd3, 0, 0, 0, "pre_dir_step_down");
    // Clear + load + due step: clear wins, prescaler restarts
    drive(2, 1, 1, 0, 0, 0, 0, 4'd3, 0, 0, 0, "pre_arm_a");
    drive(2, 1, 1, 0, 0, 0, 0, 4'd3, 0, 0, 0, "pre_arm_b");
    drive(2, 1, 1, 1, 1, 4'd5, 0, 4'd0, 0, 0, 1, "pre_clear_load_step");
    drive(2, 1, 1, 0, 0, 0, 0, 4'd0, 0, 0, 1, "pre_after_clear_a");
    drive(2, 1, 1, 0, 0, 0, 0, 4'd0, 0, 0, 1, "pre_after_clear_b");
    drive(2, 1, 1, 0, 1, 4'd5, 0, 4'd5, 0, 0, 0, "pre_load_beats_step");
    drive(2, 1, 1, 0, 0, 0, 0, 4'd5, 0, 0, 0, "pre_after_load_a");
    drive(2, 1, 1, 0, 0, 0, 0, 4'd5, 0, 0, 0, "pre_after_load_b");
    drive(2, 1, 1, 0, 0, 0, 0, 4'd6, 0, 0, 0, "pre_after_load_step");
    // Reset mid-count with a partial prescale period
    drive(2, 1, 1, 0, 0, 0, 0, 4'd6, 0, 0, 0, "pre_to7_a");
    drive(2, 1, 1, 0, 0, 0, 0, 4'd6, 0, 0, 0, "pre_to7_b");
    drive(2, 1, 1, 0, 0, 0, 0, 4'd7, 0, 0, 0, "pre_at_7");
    drive(2, 1, 1, 0, 0, 0, 0, 4'd7, 0, 0, 0, "pre_partial_at_7");
    drive(2, 1, 1, 0, 0, 0, 1, 4'd0, 0, 0, 1, "pre_reset_mid");
    drive(2, 1, 1, 0, 0, 0, 0, 4'd0, 0, 0, 1, "pre_post_reset_a");
    drive(2, 1, 1, 0, 0, 0, 0, 4'd0, 0, 0, 1, "pre_post_reset_b");
    drive(2, 1, 1, 0, 0, 0, 0, 4'd1, 0, 0, 0, "pre_post_reset_step");

    @(negedge clock);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
